// File: rtl/video_shifter.sv
// Serialises processor-written pixel bytes onto a single video pixel line,
// MSB first, each bit held for CLKS_PER_PIXEL clocks, with a one-byte holding
// register so a new byte can follow the current one with no gap pixel.
// A sync request produces a SYNC_LEN-clock videoSync pulse that blanks the
// pixel output without disturbing the shifter or the holding register.
// Optional feature: define VIDEO_OVERRUN_EN to add a sticky overrun flag that
// records any write dropped because the holding register was full.
module video_shifter #(
  parameter int CLKS_PER_PIXEL = 2,
  parameter int SYNC_LEN       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] wrData,
  input  logic       wrStrobe,
  input  logic       syncStrobe,
  output logic       ready,
  output logic       videoSync,
  output logic       videoPixel
`ifdef VIDEO_OVERRUN_EN
  ,
  output logic       overrun
`endif
);

  localparam int DIV_W  = (CLKS_PER_PIXEL > 1) ? $clog2(CLKS_PER_PIXEL) : 1;
  localparam int SYNC_W = (SYNC_LEN > 1) ? $clog2(SYNC_LEN) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLKS_PER_PIXEL - 1);
  localparam logic [SYNC_W-1:0] SYNC_LOAD = SYNC_W'(SYNC_LEN - 1);

  logic [7:0]        hold_q, hold_d;
  logic              full_q, full_d;
  logic [7:0]        shift_q, shift_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [SYNC_W-1:0] sync_cnt_q, sync_cnt_d;
  logic              video_sync_q, video_sync_d;
  logic              video_pixel_q, video_pixel_d;

  logic              pixel_end;
  logic              transfer;
  logic              accept;

  // Next-state logic: holding register, shifter/divider, sync counter, outputs.
  always_comb begin
    hold_d        = hold_q;
    full_d        = full_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    div_d         = div_q;
    sync_cnt_d    = sync_cnt_q;

    // Last divider clock of the bit currently on the line.
    pixel_end = (bit_cnt_q != 4'd0) && (div_q == DIV_LAST);
    // Holding byte moves into the shifter when idle, or seamlessly at the end
    // of the eighth bit so no gap pixel appears between bytes.
    transfer  = full_q && ((bit_cnt_q == 4'd0) || ((bit_cnt_q == 4'd1) && pixel_end));
    // A write is taken when the holding register is empty or is being
    // emptied on this very edge.
    accept    = wrStrobe && (!full_q || transfer);

    if (transfer) begin
      shift_d   = hold_q;
      bit_cnt_d = 4'd8;
      div_d     = '0;
    end else if (bit_cnt_q != 4'd0) begin
      if (pixel_end) begin
        div_d     = '0;
        shift_d   = {shift_q[6:0], 1'b0};
        bit_cnt_d = bit_cnt_q - 4'd1;
      end else begin
        div_d = div_q + 1'b1;
      end
    end

    if (accept) begin
      hold_d = wrData;
    end
    full_d = accept || (full_q && !transfer);

    // A new request always restarts the pulse at its full length.
    if (syncStrobe) begin
      sync_cnt_d = SYNC_LOAD;
    end else if (sync_cnt_q != '0) begin
      sync_cnt_d = sync_cnt_q - 1'b1;
    end

    video_sync_d  = syncStrobe || (sync_cnt_q != '0);
    // Blanking is applied against the next sync value so both outputs
    // change on the same edge.
    video_pixel_d = !video_sync_d && (bit_cnt_q != 4'd0) && shift_q[7];
  end

  // State registers, cleared immediately by the asynchronous reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_q        <= '0;
      full_q        <= 1'b0;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      div_q         <= '0;
      sync_cnt_q    <= '0;
      video_sync_q  <= 1'b0;
      video_pixel_q <= 1'b0;
    end else begin
      hold_q        <= hold_d;
      full_q        <= full_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      div_q         <= div_d;
      sync_cnt_q    <= sync_cnt_d;
      video_sync_q  <= video_sync_d;
      video_pixel_q <= video_pixel_d;
    end
  end

  assign ready      = !full_q;
  assign videoSync  = video_sync_q;
  assign videoPixel = video_pixel_q;

`ifdef VIDEO_OVERRUN_EN
  logic overrun_q, overrun_d;
  logic drop;

  // Sticky record of any write lost while the holding register was full.
  always_comb begin
    drop      = wrStrobe && full_q && !transfer;
    overrun_d = overrun_q || drop;
  end

  // Overrun flag register; only reset clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign overrun = overrun_q;
`endif

endmodule

// File: tb/tb_video_shifter.sv
// Scoreboard bench for video_shifter: each scenario pushes the expected
// {videoSync, videoPixel} pair for every clock after its first write edge,
// and each clock pops one entry and compares it with the DUT outputs.
module tb_video_shifter;

  localparam int CPP = 2;
  localparam int SL  = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] wr_data;
  logic       wr_strobe;
  logic       sync_strobe;
  logic       ready;
  logic       videoSync;
  logic       videoPixel;
`ifdef VIDEO_OVERRUN_EN
  logic       overrun;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [1:0] sb[$];

  always #5 clk = ~clk;

  video_shifter #(
    .CLKS_PER_PIXEL(CPP),
    .SYNC_LEN(SL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .wrData(wr_data),
    .wrStrobe(wr_strobe),
    .syncStrobe(sync_strobe),
    .ready(ready),
    .videoSync(videoSync),
    .videoPixel(videoPixel)
`ifdef VIDEO_OVERRUN_EN
    ,
    .overrun(overrun)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_n(input logic [1:0] v, input int n);
    repeat (n) sb.push_back(v);
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) push_n({1'b0, b[i]}, CPP);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One clock: strobes are one-shot, then the next scoreboard entry is checked.
  task automatic cyc(input string tag);
    logic [1:0] e;
    tick;
    wr_strobe   = 1'b0;
    sync_strobe = 1'b0;
    chk({tag, "_sb_nonempty"}, sb.size() > 0, 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_sync"}, videoSync, e[1]);
      chk({tag, "_pix"}, videoPixel, e[0]);
    end
  endtask

  task automatic drain(input string tag);
    while (sb.size() > 0) cyc(tag);
  endtask

  task automatic write(input logic [7:0] b);
    wr_data   = b;
    wr_strobe = 1'b1;
  endtask

  initial begin
    reset       = 1'b1;
    wr_data     = 8'h00;
    wr_strobe   = 1'b0;
    sync_strobe = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_sync", videoSync, 0);
    chk("rst_pix", videoPixel, 0);
`ifdef VIDEO_OVERRUN_EN
    chk("rst_overrun", overrun, 0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // A5 written on the first edge after reset release.
    write(8'hA5);
    push_n(2'b00, 2);
    push_byte(8'hA5);
    push_n(2'b00, 4);
    cyc("a");
    chk("a_ready_full", ready, 0);
    cyc("a");
    chk("a_ready_xfer", ready, 1);
    drain("a");

    // FF then 00 back to back.
    push_n(2'b00, 2);
    push_byte(8'hFF);
    push_byte(8'h00);
    push_n(2'b00, 2);
    write(8'hFF);
    cyc("b");
    cyc("b");
    chk("b_ready_after_xfer", ready, 1);
    write(8'h00);
    cyc("b");
    chk("b_ready_held", ready, 0);
    drain("b");

    // Holding full while shifting: 3C is dropped.
    push_n(2'b00, 2);
    push_byte(8'hFF);
    push_byte(8'h55);
    push_n(2'b00, 4);
    write(8'hFF);
    cyc("c");
    cyc("c");
    write(8'h55);
    cyc("c");
    cyc("c");
    write(8'h3C);
    cyc("c");
    chk("c_ready_still_full", ready, 0);
`ifdef VIDEO_OVERRUN_EN
    chk("c_overrun", overrun, 1);
`endif
    drain("c");

    // Two sync requests 3 clocks apart over a streaming FF byte.
    push_n(2'b00, 2);
    push_n(2'b01, 2);
    push_n(2'b10, 11);
    push_n(2'b01, 3);
    push_n(2'b00, 3);
    write(8'hFF);
    cyc("d");
    cyc("d");
    cyc("d");
    cyc("d");
    sync_strobe = 1'b1;
    cyc("d");
    cyc("d");
    cyc("d");
    sync_strobe = 1'b1;
    drain("d");

    // Reset during the 4th bit of F0 while a sync pulse is active.
    push_n(2'b00, 2);
    push_n(2'b01, 4);
    push_n(2'b10, 3);
    write(8'hF0);
    for (int i = 0; i < 6; i++) cyc("e");
    sync_strobe = 1'b1;
    drain("e");
    reset = 1'b0;
    #1;
    chk("e_rst_pix", videoPixel, 0);
    chk("e_rst_sync", videoSync, 0);
    chk("e_rst_ready", ready, 1);
`ifdef VIDEO_OVERRUN_EN
    chk("e_rst_overrun", overrun, 0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    push_n(2'b00, 20);
    drain("e_post");

    // 7E written on the idle-transfer edge of 81 while full.
    push_n(2'b00, 2);
    push_byte(8'h81);
    push_byte(8'h7E);
    push_n(2'b00, 4);
    write(8'h81);
    cyc("f");
    chk("f_ready_full", ready, 0);
    write(8'h7E);
    cyc("f");
    chk("f_ready_refilled", ready, 0);
    drain("f");
    chk("f_ready_end", ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
